// File: rtl/chip_invaders_pkg.sv
// Shared types and defaults for the chip_invaders game blocks.
//   fire_state_t : alien fire controller FSM states
//   shot_t       : one alien shot offered to the bullet engine
//   ALIEN_W_DEF / ALIEN_H_DEF : default alien sprite size in pixels
package chip_invaders_pkg;

    localparam int ALIEN_W_DEF    = 32;
    localparam int ALIEN_H_DEF    = 16;
    // Column field is sized for the widest formation we support; users slice it down.
    localparam int SHOT_COL_MAX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        COOLDOWN,
        SCAN,
        OFFER
    } fire_state_t;

    typedef struct packed {
        logic [15:0]               x;
        logic [15:0]               y;
        logic [SHOT_COL_MAX_W-1:0] col;
    } shot_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 (shift right, mask 0xB400).
// A non-zero seed keeps the register out of the all-zero lock-up state forever.
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset, loads SEED
//   en_i    : advance one step this cycle
//   state_o : current register contents
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // NOTE: combinational blocks assign every output a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/alien_fire_controller.sv
// Decides when and from which alien the formation fires, and offers each shot to the
// alien-bullet engine over a valid/ready handshake. A tick-based cooldown paces the
// attempts and an in-flight counter caps the number of live alien bullets.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable_i              : game running; low parks the FSM in IDLE (except mid-offer)
//   tick_i                : one-cycle game-tick strobe, paces the cooldown
//   armed_matrix_i        : bit r*NUM_COLS+c set = alien (row r, col c) may fire
//   alien_pos_x_i/_y_i    : 16-bit top-left coordinates, slot r*NUM_COLS+c
//   shot_valid_o          : shot offered; held with stable data until accepted
//   shot_ready_i          : bullet engine accepts the shot
//   shot_x_o/_y_o/_col_o  : bullet spawn point and firing column
//   bullet_retired_i      : one-cycle pulse, an alien bullet left play
//   bullets_in_flight_o   : current live alien bullet count
module alien_fire_controller
    import chip_invaders_pkg::*;
#(
    parameter int          NUM_ROWS      = 3,
    parameter int          NUM_COLS      = 5,
    parameter int          FIRE_INTERVAL = 100,
    parameter int          MAX_BULLETS   = 2,
    parameter int          ALIEN_W       = ALIEN_W_DEF,
    parameter int          ALIEN_H       = ALIEN_H_DEF,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    localparam int         COL_W         = $clog2(NUM_COLS),
    localparam int         IF_W          = $clog2(MAX_BULLETS + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable_i,
    input  logic                            tick_i,
    input  logic [NUM_ROWS*NUM_COLS-1:0]    armed_matrix_i,
    input  logic [16*NUM_ROWS*NUM_COLS-1:0] alien_pos_x_i,
    input  logic [16*NUM_ROWS*NUM_COLS-1:0] alien_pos_y_i,
    output logic                            shot_valid_o,
    input  logic                            shot_ready_i,
    output logic [15:0]                     shot_x_o,
    output logic [15:0]                     shot_y_o,
    output logic [COL_W-1:0]                shot_col_o,
    input  logic                            bullet_retired_i,
    output logic [IF_W-1:0]                 bullets_in_flight_o
);

    localparam int               CD_W      = $clog2(FIRE_INTERVAL + 1);
    localparam logic [CD_W-1:0]  CD_RELOAD = CD_W'(FIRE_INTERVAL);
    localparam logic [IF_W-1:0]  IF_MAX    = IF_W'(MAX_BULLETS);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLS - 1);
    localparam logic [15:0]      X_OFS     = 16'(ALIEN_W / 2);
    localparam logic [15:0]      Y_OFS     = 16'(ALIEN_H);

    fire_state_t      state_q,     state_d;
    logic [CD_W-1:0]  cooldown_q,  cooldown_d;
    logic [COL_W-1:0] scan_col_q,  scan_col_d;
    logic [COL_W-1:0] scan_cnt_q,  scan_cnt_d;
    logic [IF_W-1:0]  in_flight_q, in_flight_d;
    shot_t            shot_q,      shot_d;

    logic [15:0] lfsr;
    logic        accept;
    logic        col_hit;
    logic [15:0] hit_x;
    logic [15:0] hit_y;
    logic        unused_bits;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (1'b1),
        .state_o(lfsr)
    );

    // Random start column, always in 0..NUM_COLS-1.
    function automatic logic [COL_W-1:0] start_col(input logic [7:0] v);
        logic [7:0] m;
        m = v % 8'(NUM_COLS);
        return COL_W'(m);
    endfunction

    // Column under scan: any armed alien is a hit. Rows are walked upward so the
    // last match, i.e. the highest armed row, supplies the spawn position.
    always_comb begin
        col_hit = 1'b0;
        hit_x   = '0;
        hit_y   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (scan_col_q == COL_W'(c) && armed_matrix_i[r*NUM_COLS+c]) begin
                    col_hit = 1'b1;
                    hit_x   = alien_pos_x_i[(r*NUM_COLS+c)*16 +: 16];
                    hit_y   = alien_pos_y_i[(r*NUM_COLS+c)*16 +: 16];
                end
            end
        end
    end

    assign accept = (state_q == OFFER) && shot_ready_i;

    always_comb begin
        state_d    = state_q;
        cooldown_d = cooldown_q;
        scan_col_d = scan_col_q;
        scan_cnt_d = scan_cnt_q;
        shot_d     = shot_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d    = COOLDOWN;
                    cooldown_d = CD_RELOAD;
                end
            end
            COOLDOWN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (cooldown_q != '0) begin
                    if (tick_i) cooldown_d = cooldown_q - 1'b1;
                end else if (in_flight_q < IF_MAX || bullet_retired_i) begin
                    // A retire this cycle frees a slot, so scanning may start at once.
                    state_d    = SCAN;
                    scan_col_d = start_col(lfsr[7:0]);
                    scan_cnt_d = '0;
                end
            end
            SCAN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (col_hit) begin
                    state_d    = OFFER;
                    shot_d.x   = hit_x + X_OFS;
                    shot_d.y   = hit_y + Y_OFS;
                    shot_d.col = SHOT_COL_MAX_W'(scan_col_q);
                end else if (scan_cnt_q == LAST_COL) begin
                    // Every column examined without an armed alien: give up this round.
                    state_d    = COOLDOWN;
                    cooldown_d = CD_RELOAD;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                    scan_col_d = (scan_col_q == LAST_COL) ? '0 : scan_col_q + 1'b1;
                end
            end
            OFFER: begin
                // The offer is never withdrawn; enable_i only picks where we go afterwards.
                if (shot_ready_i) begin
                    state_d    = enable_i ? COOLDOWN : IDLE;
                    cooldown_d = CD_RELOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_flight_d = in_flight_q;
        if (accept && !bullet_retired_i) begin
            in_flight_d = in_flight_q + 1'b1;
        end else if (!accept && bullet_retired_i && in_flight_q != '0) begin
            in_flight_d = in_flight_q - 1'b1;
        end
    end

    // NOTE: every register, shot payload included, is reset so an abort mid-offer leaves no stale shot visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cooldown_q  <= CD_RELOAD;
            scan_col_q  <= '0;
            scan_cnt_q  <= '0;
            in_flight_q <= '0;
            shot_q      <= '0;
        end else begin
            state_q     <= state_d;
            cooldown_q  <= cooldown_d;
            scan_col_q  <= scan_col_d;
            scan_cnt_q  <= scan_cnt_d;
            in_flight_q <= in_flight_d;
            shot_q      <= shot_d;
        end
    end

    assign shot_valid_o        = (state_q == OFFER);
    assign shot_x_o            = shot_q.x;
    assign shot_y_o            = shot_q.y;
    assign shot_col_o          = shot_q.col[COL_W-1:0];
    assign bullets_in_flight_o = in_flight_q;

    // Upper column-field bits and the high LFSR byte have no consumer.
    assign unused_bits = ^{shot_q.col[SHOT_COL_MAX_W-1:COL_W], lfsr[15:8]};

endmodule

// File: tb/tb_alien_fire_controller.sv
// Self-checking bench for alien_fire_controller. Directed stimulus pushes the expected
// shot into a scoreboard queue; a monitor pops and compares on every handshake.
module tb_alien_fire_controller;

    localparam int          NR   = 3;
    localparam int          NC   = 5;
    localparam int          FI   = 3;
    localparam int          MB   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [2:0]  col;
    } exp_t;

    logic                  clk    = 1'b0;
    logic                  rst_n  = 1'b0;
    logic                  enable = 1'b0;
    logic                  tick   = 1'b0;
    logic                  ready  = 1'b0;
    logic                  retire = 1'b0;
    logic [NR*NC-1:0]      armed;
    logic [16*NR*NC-1:0]   pos_x_flat;
    logic [16*NR*NC-1:0]   pos_y_flat;
    logic [15:0]           px [NR][NC];
    logic [15:0]           py [NR][NC];
    logic                  valid;
    logic [15:0]           sx;
    logic [15:0]           sy;
    logic [2:0]            scol;
    logic [1:0]            inflight;
    logic [15:0]           m_lfsr;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    alien_fire_controller #(
        .NUM_ROWS     (NR),
        .NUM_COLS     (NC),
        .FIRE_INTERVAL(FI),
        .MAX_BULLETS  (MB),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable_i           (enable),
        .tick_i             (tick),
        .armed_matrix_i     (armed),
        .alien_pos_x_i      (pos_x_flat),
        .alien_pos_y_i      (pos_y_flat),
        .shot_valid_o       (valid),
        .shot_ready_i       (ready),
        .shot_x_o           (sx),
        .shot_y_o           (sy),
        .shot_col_o         (scol),
        .bullet_retired_i   (retire),
        .bullets_in_flight_o(inflight)
    );

    always #5 clk = ~clk;

    always_comb begin
        pos_x_flat = '0;
        pos_y_flat = '0;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                pos_x_flat[(r*NC+c)*16 +: 16] = px[r][c];
                pos_y_flat[(r*NC+c)*16 +: 16] = py[r][c];
            end
        end
    end

    // Reference LFSR: Galois x^16+x^14+x^13+x^11, stepping every clock from the seed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid&&ready seen between edges is a handshake on the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid && ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_shot: got col %0d x %0d, none expected", scol, sx);
            end else begin
                e = sb.pop_front();
                check("shot_x", 32'(sx), 32'(e.x));
                check("shot_y", 32'(sy), 32'(e.y));
                check("shot_col", 32'(scol), 32'(e.col));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!valid && n < NC + 4) begin
            step();
            n++;
        end
        if (!valid) begin
            total++;
            bad++;
            $display("FAIL %s: valid not seen within %0d cycles", name, n);
        end
    endtask

    // Start column the DUT will latch on the next edge.
    function automatic int next_start();
        return int'(m_lfsr[7:0]) % NC;
    endfunction

    task automatic push_row2(input int s);
        exp_t e;
        e.x   = px[2][s] + 16'd16;
        e.y   = py[2][s] + 16'd16;
        e.col = 3'(s);
        sb.push_back(e);
    endtask

    initial begin
        int   n;
        int   s;
        int   seen;
        exp_t e;

        armed = '1;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                px[r][c] = 16'(40 * c + 4 * r + 20);
                py[r][c] = 16'(20 * r + 30);
            end
        end
        px[2][4] = 16'd356;
        py[2][4] = 16'd114;
        enable   = 1'b1;

        // Reset values.
        #3;
        check("rst_valid", 32'(valid), 0);
        check("rst_inflight", 32'(inflight), 0);
        check("rst_x", 32'(sx), 0);
        check("rst_y", 32'(sy), 0);
        check("rst_col", 32'(scol), 0);

        // Retire at zero is ignored; also takes IDLE -> COOLDOWN.
        retire = 1'b1;
        #9;
        rst_n = 1'b1;
        step();
        retire = 1'b0;
        check("retire_at_zero", 32'(inflight), 0);

        // 1: all armed, first scanned column hits, highest row fires.
        ready = 1'b1;
        do_ticks(FI);
        s = next_start();
        push_row2(s);
        wait_valid("first_shot", n);
        check("first_shot_latency", 32'(n), 2);
        step();
        check("first_inflight", 32'(inflight), 1);
        check("first_valid_drop", 32'(valid), 0);

        // 2: only col 4 armed; scan length depends on the start column.
        armed = '0;
        armed[2*NC+4] = 1'b1;
        do_ticks(FI);
        s = next_start();
        e.x = 16'd372; e.y = 16'd130; e.col = 3'd4;
        sb.push_back(e);
        wait_valid("col4_shot", n);
        check("col4_latency", 32'(n), 32'(1 + ((4 - s + NC) % NC) + 1));
        step();
        check("col4_inflight", 32'(inflight), 2);

        // 3: at MAX_BULLETS the FSM holds; a retire releases it immediately.
        armed = '1;
        ready = 1'b0;
        do_ticks(FI);
        seen = 0;
        repeat (10) begin
            step();
            if (valid) seen++;
        end
        check("hold_at_max", 32'(seen), 0);
        retire = 1'b1;
        s = next_start();
        push_row2(s);
        step();
        retire = 1'b0;
        check("retire_dec", 32'(inflight), 1);
        wait_valid("after_retire", n);
        check("after_retire_latency", 32'(n), 1);
        ready  = 1'b1;
        retire = 1'b1;
        step();
        ready  = 1'b0;
        retire = 1'b0;
        check("accept_and_retire", 32'(inflight), 1);

        // 4: no armed aliens -> no shot for a full scan, then cooldown reload.
        armed = '0;
        do_ticks(FI);
        seen = 0;
        repeat (NC + 5) begin
            step();
            if (valid) seen++;
        end
        check("empty_scan_no_valid", 32'(seen), 0);
        armed = '1;
        do_ticks(FI - 1);
        seen = 0;
        repeat (NC + 3) begin
            step();
            if (valid) seen++;
        end
        check("reload_no_early_shot", 32'(seen), 0);

        // 5: held offer with 16-bit wrap; alien dies, positions move, enable falls.
        for (int c = 0; c < NC; c++) px[2][c] = 16'hFFF0 + 16'(c);
        do_ticks(1);
        s = next_start();
        push_row2(s);
        e.x = 16'(s); e.y = py[2][s] + 16'd16; e.col = 3'(s);
        wait_valid("held_shot", n);
        check("held_latency", 32'(n), 2);
        repeat (10) begin
            armed  = '0;
            enable = 1'b0;
            for (int r = 0; r < NR; r++) begin
                for (int c = 0; c < NC; c++) begin
                    px[r][c] = px[r][c] + 16'd7;
                    py[r][c] = py[r][c] + 16'd7;
                end
            end
            step();
            check("held_valid", 32'(valid), 1);
            check("held_x", 32'(sx), 32'(e.x));
            check("held_y", 32'(sy), 32'(e.y));
            check("held_col", 32'(scol), 32'(e.col));
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("held_inflight", 32'(inflight), 2);
        step();
        check("idle_no_valid", 32'(valid), 0);

        // 6: asynchronous reset mid-offer.
        armed  = '1;
        enable = 1'b1;
        retire = 1'b1;
        step();
        retire = 1'b0;
        check("pre_reset_inflight", 32'(inflight), 1);
        do_ticks(FI);
        wait_valid("reset_shot", n);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_valid", 32'(valid), 0);
        check("reset_inflight", 32'(inflight), 0);
        #3;
        rst_n = 1'b1;
        check("reset_lfsr_seed", 32'(dut.u_lfsr.state_o), 32'(SEED));
        step();
        check("post_reset_valid", 32'(valid), 0);

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
